fill_header_builder: RTL and testbench

FILL_HEADER_BUILDER -- requirements
Module: fill_header_builder

---
 rtl/fill_header_builder.sv | 183 ++++++++++++++++++
 tb/tb_fill_header_builder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fill_header_builder.sv
// fill_header_builder
//   Collects the per-fill metadata (trigger number, fill type, async flag,
//   DDR3 start address, burst count) between fill_start and wfm_done and
//   pushes exactly one 152-bit header word into the fill header FIFO for
//   every accepted fill.
//   Optional feature: define FILL_HDR_TIMESTAMP_EN to build a free-running
//   26-bit cycle counter whose value at fill_start lands in bits [52:27].
//   Without the macro no counter exists and those bits are zero.
module fill_header_builder #(
  parameter int HDR_BURSTS  = 2,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         fill_start,
  input  logic [23:0]  trig_num,
  input  logic [1:0]   fill_type,
  input  logic         async_mode,
  input  logic [22:0]  ddr3_wr_start_addr,
  input  logic         wfm_done,
  input  logic [23:0]  bursts_written,
  input  logic         fill_header_fifo_full,
  output logic         fill_header_fifo_wr_en,
  output logic [151:0] fill_header_fifo_in,
  output logic         busy,
  output logic [15:0]  drop_count
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    WAIT_FIFO = 2'd2,
    WRITE     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_cnt;
  logic          ovl_flag;

  // Fields captured at fill_start; they only matter once a fill is accepted.
  logic [23:0]   trig_q;
  logic [1:0]    type_q;
  logic          async_q;
  logic [22:0]   addr_q;
  logic [25:0]   ts_q;

  logic          accept;
  logic          drop;
  logic          tmo_hit;
  logic          hdr_load;
  logic          hdr_tmo;
  logic          hdr_ovl;
  logic [23:0]   hdr_bursts;

  // Burst total widened to 25 bits so the carry shows up, then clamped.
  function automatic logic [23:0] sat_total(input logic [23:0] bursts);
    logic [24:0] sum;
    sum = {1'b0, bursts} + 25'(HDR_BURSTS);
    return sum[24] ? 24'hFFFFFF : sum[23:0];
  endfunction

  // Drop counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Assemble the header word; the burst total appears twice so the
  // downstream reader can find it in either 128-bit half.
  function automatic logic [151:0] build_word(
    input logic [23:0] trig,
    input logic [1:0]  ftype,
    input logic        amode,
    input logic [25:0] ts,
    input logic [22:0] addr,
    input logic [23:0] total,
    input logic        tmo,
    input logic        ovl
  );
    logic [151:0] w;
    w           = '0;
    w[23:0]     = trig;
    w[25:24]    = ftype;
    w[26]       = amode;
    w[52:27]    = ts;
    w[75:53]    = addr;
    w[99:76]    = total;
    w[100]      = tmo;
    w[101]      = ovl;
    w[151:128]  = total;
    return w;
  endfunction

  assign accept   = fill_start && (state_q == IDLE);
  assign drop     = fill_start && (state_q != IDLE);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign hdr_load = (state_q == ARMED) && (wfm_done || tmo_hit);
  // wfm_done wins over a simultaneous terminal count.
  assign hdr_tmo  = !wfm_done;
  // A second fill_start coinciding with wfm_done still marks the overlap.
  assign hdr_ovl  = ovl_flag || fill_start;
  assign hdr_bursts = wfm_done ? bursts_written : 24'd0;
  assign busy     = (state_q != IDLE);

`ifdef FILL_HDR_TIMESTAMP_EN
  logic [25:0] ts_cnt;

  // Free-running cycle counter, wraps naturally at 26 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 26'd1;
    end
  end

  // Snapshot the timestamp together with the other fill fields.
  always_ff @(posedge clk) begin
    if (accept) begin
      ts_q <= ts_cnt;
    end
  end
`else
  assign ts_q = '0;
`endif

  // Capture the fill descriptor when a fill is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      trig_q  <= trig_num;
      type_q  <= fill_type;
      async_q <= async_mode;
      addr_q  <= ddr3_wr_start_addr;
    end
  end

  // Next-state logic for the fill sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fill_start)             state_d = ARMED;
      ARMED:     if (wfm_done || tmo_hit)    state_d = WAIT_FIFO;
      WAIT_FIFO: if (!fill_header_fifo_full) state_d = WRITE;
      WRITE:                                 state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // State register, timeout/overlap tracking, drop counter and header output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= IDLE;
      tmo_cnt                <= '0;
      ovl_flag               <= 1'b0;
      drop_count             <= '0;
      fill_header_fifo_wr_en <= 1'b0;
      fill_header_fifo_in    <= '0;
    end else begin
      state_q                <= state_d;
      // wr_en mirrors the WRITE state one-for-one, registered.
      fill_header_fifo_wr_en <= (state_q == WAIT_FIFO) && !fill_header_fifo_full;
      if (drop) begin
        drop_count <= sat_inc16(drop_count);
      end
      if (accept) begin
        tmo_cnt  <= '0;
        ovl_flag <= 1'b0;
      end else if (state_q == ARMED) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (fill_start) begin
          ovl_flag <= 1'b1;
        end
        // Header is frozen here and held through WAIT_FIFO and WRITE.
        if (hdr_load) begin
          fill_header_fifo_in <= build_word(trig_q, type_q, async_q, ts_q, addr_q,
                                            sat_total(hdr_bursts), hdr_tmo, hdr_ovl);
        end
      end
    end
  end

endmodule

// File: tb/tb_fill_header_builder.sv
// Directed bench for fill_header_builder (TIMEOUT_CYC shortened to 64).
module tb_fill_header_builder;

  localparam int HDR  = 2;
  localparam int TMO  = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fill_start;
  logic [23:0]  trig_num;
  logic [1:0]   fill_type;
  logic         async_mode;
  logic [22:0]  ddr3_wr_start_addr;
  logic         wfm_done;
  logic [23:0]  bursts_written;
  logic         fill_header_fifo_full;
  logic         fill_header_fifo_wr_en;
  logic [151:0] fill_header_fifo_in;
  logic         busy;
  logic [15:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  fill_header_builder #(.HDR_BURSTS(HDR), .TIMEOUT_CYC(TMO)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .fill_start             (fill_start),
    .trig_num               (trig_num),
    .fill_type              (fill_type),
    .async_mode             (async_mode),
    .ddr3_wr_start_addr     (ddr3_wr_start_addr),
    .wfm_done               (wfm_done),
    .bursts_written         (bursts_written),
    .fill_header_fifo_full  (fill_header_fifo_full),
    .fill_header_fifo_wr_en (fill_header_fifo_wr_en),
    .fill_header_fifo_in    (fill_header_fifo_in),
    .busy                   (busy),
    .drop_count             (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_header_fifo_wr_en === 1'b1) wr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [151:0] exp_word(input logic [23:0] trig, input logic [1:0] ft,
                                             input logic as, input logic [22:0] addr,
                                             input logic [23:0] total, input logic tmo,
                                             input logic ovl);
    return {total, 26'd0, ovl, tmo, total, addr, 26'd0, as, ft, trig};
  endfunction

  task automatic chk_word(input string tag, input logic [151:0] exp);
    logic [151:0] e;
    e = exp;
`ifdef FILL_HDR_TIMESTAMP_EN
    e[52:27] = fill_header_fifo_in[52:27];
`endif
    chk(tag, fill_header_fifo_in, e);
  endtask

  task automatic start_fill(input logic [23:0] trig, input logic [22:0] addr,
                            input logic [1:0] ft, input logic as);
    fill_start = 1'b1; trig_num = trig; ddr3_wr_start_addr = addr;
    fill_type = ft; async_mode = as;
    tick();
    fill_start = 1'b0;
  endtask

  // Full fill with FIFO empty: checks 2-edge latency, word and return to IDLE.
  task automatic do_fill(input string tag, input logic [23:0] trig, input logic [22:0] addr,
                         input logic [1:0] ft, input logic as, input logic [23:0] bw,
                         input logic [23:0] exp_total);
    start_fill(trig, addr, ft, as);
    chk({tag, "_busy"}, 152'(busy), 152'(1));
    tick(); tick();
    wfm_done = 1'b1; bursts_written = bw;
    tick();
    wfm_done = 1'b0;
    chk({tag, "_wr_e1"}, 152'(fill_header_fifo_wr_en), 152'(0));
    tick();
    chk({tag, "_wr_e2"}, 152'(fill_header_fifo_wr_en), 152'(1));
    chk_word({tag, "_word"}, exp_word(trig, ft, as, addr, exp_total, 1'b0, 1'b0));
    tick();
    chk({tag, "_idle"}, 152'({fill_header_fifo_wr_en, busy}), 152'(0));
  endtask

  initial begin
    int n;
    int w0;
    int bad;
    reset_n = 1'b0; fill_start = 1'b0; trig_num = '0; fill_type = '0; async_mode = 1'b0;
    ddr3_wr_start_addr = '0; wfm_done = 1'b0; bursts_written = '0; fill_header_fifo_full = 1'b0;
    tick(); tick(); tick();
    chk("rst_wr_en", 152'(fill_header_fifo_wr_en), 152'(0));
    chk("rst_word",  fill_header_fifo_in, 152'(0));
    chk("rst_busy",  152'(busy), 152'(0));
    chk("rst_drop",  152'(drop_count), 152'(0));
    reset_n = 1'b1;

    // Basic fill, started in the very first cycle after reset release.
    w0 = wr_cnt;
    do_fill("basic", 24'd5, 23'h000100, 2'd1, 1'b0, 24'd1000, 24'd1002);
    chk("basic_total", 152'(fill_header_fifo_in[151:128]), 152'(1002));
    chk("basic_count", 152'(wr_cnt - w0), 152'(1));

    // Timeout: bursts_written ignored, TMO set, total = header bursts only.
    bursts_written = 24'h000123;
    start_fill(24'd7, 23'h000200, 2'd3, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!fill_header_fifo_wr_en && n < 200);
    chk("tmo_latency", 152'(n), 152'(TMO + 1));
    chk_word("tmo_word", exp_word(24'd7, 2'd3, 1'b1, 23'h000200, 24'(HDR), 1'b1, 1'b0));
    tick();

    // wfm_done arriving on the terminal-count cycle wins; TMO stays clear.
    start_fill(24'd8, 23'h000280, 2'd0, 1'b0);
    repeat (TMO - 1) tick();
    wfm_done = 1'b1; bursts_written = 24'd40;
    tick();
    wfm_done = 1'b0;
    tick();
    chk("race_wr", 152'(fill_header_fifo_wr_en), 152'(1));
    chk_word("race_word", exp_word(24'd8, 2'd0, 1'b0, 23'h000280, 24'd42, 1'b0, 1'b0));
    tick();

    // Overlap: second fill_start while ARMED is dropped and flagged.
    start_fill(24'd9, 23'h000300, 2'd2, 1'b0);
    tick();
    start_fill(24'd10, 23'h7FFFFF, 2'd1, 1'b1);
    chk("ovl_drop", 152'(drop_count), 152'(1));
    wfm_done = 1'b1; bursts_written = 24'd10;
    tick();
    wfm_done = 1'b0;
    tick();
    chk("ovl_wr", 152'(fill_header_fifo_wr_en), 152'(1));
    chk_word("ovl_word", exp_word(24'd9, 2'd2, 1'b0, 23'h000300, 24'd12, 1'b0, 1'b1));
    tick();

    // FIFO full for 50 cycles with a dropped fill_start in WAIT_FIFO.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("full_rst_drop", 152'(drop_count), 152'(0));
    start_fill(24'hABCDEF, 23'h7FFFFF, 2'd2, 1'b1);
    tick();
    fill_header_fifo_full = 1'b1;
    wfm_done = 1'b1; bursts_written = 24'h000010;
    tick();
    wfm_done = 1'b0;
    w0 = wr_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      fill_start = (i == 10);
      if (fill_header_fifo_wr_en) bad++;
      tick();
    end
    fill_start = 1'b0;
    chk("full_no_write", 152'(bad + (wr_cnt - w0)), 152'(0));
    chk("full_drop", 152'(drop_count), 152'(1));
    chk("full_busy", 152'(busy), 152'(1));
    fill_header_fifo_full = 1'b0;
    tick();
    chk("full_wr", 152'(fill_header_fifo_wr_en), 152'(1));
    chk_word("full_word", exp_word(24'hABCDEF, 2'd2, 1'b1, 23'h7FFFFF, 24'h000012, 1'b0, 1'b0));
    tick();
    tick();
    chk("full_count", 152'(wr_cnt - w0), 152'(1));

    // Saturation boundaries of the burst total.
    do_fill("sat_max", 24'd11, 23'h000010, 2'd0, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    do_fill("sat_edge", 24'd12, 23'h000020, 2'd0, 1'b0, 24'hFFFFFD, 24'hFFFFFF);
    do_fill("sat_below", 24'd13, 23'h000030, 2'd0, 1'b0, 24'hFFFFFC, 24'hFFFFFE);

    // Reset while ARMED discards the pending header.
    start_fill(24'd14, 23'h000040, 2'd1, 1'b0);
    tick();
    reset_n = 1'b0;
    tick(); tick(); tick();
    chk("mrst_out", 152'({fill_header_fifo_wr_en, busy, drop_count}), 152'(0));
    chk("mrst_word", fill_header_fifo_in, 152'(0));
    reset_n = 1'b1;
    w0 = wr_cnt;
    repeat (TMO + 20) tick();
    chk("mrst_no_write", 152'(wr_cnt - w0), 152'(0));
    do_fill("after_rst", 24'd15, 23'h000050, 2'd3, 1'b1, 24'd7, 24'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
